// File: rtl/alu_pkg.sv
// Shared ALU result-stage types: status bits, branch codes,
// skid buffer states and the buffered entry layout.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  localparam int STS_Z = 2;
  localparam int STS_N = 1;
  localparam int STS_V = 0;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_Z    = 3'b001;
  localparam logic [2:0] BR_NZ   = 3'b010;
  localparam logic [2:0] BR_N    = 3'b011;
  localparam logic [2:0] BR_NN   = 3'b100;
  localparam logic [2:0] BR_V    = 3'b101;
  localparam logic [2:0] BR_AL   = 3'b110;
  localparam logic [2:0] BR_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic [RD_W-1:0]   rd;
    logic              regwrite;
    logic              taken;
  } entry_t;

endpackage

// File: rtl/alu_status_stage_cond.sv
// Branch condition evaluation against a 3-bit flag set.
// Shared with the fetch-side predictor check.
module status_cond_eval
  import alu_pkg::*;
(
  input  logic [2:0] i_flags,
  input  logic [2:0] i_brcond,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    unique case (i_brcond)
      BR_NONE: o_taken = 1'b0;
      BR_Z:    o_taken = i_flags[STS_Z];
      BR_NZ:   o_taken = ~i_flags[STS_Z];
      BR_N:    o_taken = i_flags[STS_N];
      BR_NN:   o_taken = ~i_flags[STS_N];
      BR_V:    o_taken = i_flags[STS_V];
      BR_AL:   o_taken = 1'b1;
      BR_RSVD: o_taken = 1'b0;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_status_stage.sv
// ALU result stage: owns SR, resolves branches at accept,
// and buffers results in a two-entry skid buffer.
module alu_status_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int RW    = RD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [2:0]       in_status,
  input  logic             in_stswrite,
  input  logic [2:0]       in_brcond,
  input  logic [RW-1:0]    in_rd,
  input  logic             in_regwrite,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [RW-1:0]    out_rd,
  output logic             out_regwrite,
  output logic             out_taken,
  output logic [2:0]       sr
);

  skid_state_e r_state;
  skid_state_e w_nstate;
  entry_t      r_main;
  entry_t      r_skid;
  entry_t      w_in;
  logic [2:0]  r_sr;
  logic [2:0]  w_flags;
  logic        w_taken;
  logic        w_accept;
  logic        w_pop;
  logic        w_ld_main;
  logic        w_ld_from_skid;
  logic        w_ld_skid;

  assign in_ready  = (r_state != ST_TWO);
  assign out_valid = (r_state != ST_EMPTY);

  assign w_accept = in_valid & in_ready & ~flush;
  assign w_pop    = out_valid & out_ready;

  // An instruction that writes SR branches on its own new flags
  assign w_flags = in_stswrite ? in_status : r_sr;

  status_cond_eval u_cond (
    .i_flags  (w_flags),
    .i_brcond (in_brcond),
    .o_taken  (w_taken)
  );

  assign w_in = '{
    sum:      in_sum,
    rd:       in_rd,
    regwrite: in_regwrite,
    taken:    w_taken
  };

  always_comb begin
    w_nstate       = r_state;
    w_ld_main      = 1'b0;
    w_ld_from_skid = 1'b0;
    w_ld_skid      = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_nstate  = ST_ONE;
          w_ld_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_pop) begin
          w_ld_main = 1'b1;
        end else if (w_accept) begin
          w_nstate  = ST_TWO;
          w_ld_skid = 1'b1;
        end else if (w_pop) begin
          w_nstate = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_nstate       = ST_ONE;
          w_ld_from_skid = 1'b1;
        end
      end
      default: w_nstate = ST_EMPTY;
    endcase
    // Dropped entries leave the visible outputs untouched
    if (flush) begin
      w_nstate       = ST_EMPTY;
      w_ld_main      = 1'b0;
      w_ld_from_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_ld_main) begin
        r_main <= w_in;
      end else if (w_ld_from_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= w_in;
      end
      if (w_accept && in_stswrite) begin
        r_sr <= in_status;
      end
    end
  end

  assign out_sum      = r_main.sum;
  assign out_rd       = r_main.rd;
  assign out_regwrite = r_main.regwrite;
  assign out_taken    = r_main.taken;
  assign sr           = r_sr;

endmodule

// File: tb/tb_alu_status_stage.sv
// Directed bench for alu_status_stage: vector table for
// streaming/branch codes, plus skid, flush and reset sequences.
module tb_alu_status_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sum;
  logic [2:0]  in_status;
  logic        in_stswrite;
  logic [2:0]  in_brcond;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [4:0]  out_rd;
  logic        out_regwrite;
  logic        out_taken;
  logic [2:0]  sr;

  int checks;
  int failures;

  alu_status_stage #(.WIDTH(32), .RW(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_status    (in_status),
    .in_stswrite  (in_stswrite),
    .in_brcond    (in_brcond),
    .in_rd        (in_rd),
    .in_regwrite  (in_regwrite),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_rd       (out_rd),
    .out_regwrite (out_regwrite),
    .out_taken    (out_taken),
    .sr           (sr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic [4:0]  rd;
    logic        rw;
    logic [2:0]  st;
    logic        sw;
    logic [2:0]  br;
    logic        exp_tk;
    logic [2:0]  exp_sr;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] s,
                       input logic [4:0] rd, input logic rw,
                       input logic [2:0] st, input logic sw,
                       input logic [2:0] br);
    in_valid    = v;
    in_sum      = s;
    in_rd       = rd;
    in_regwrite = rw;
    in_status   = st;
    in_stswrite = sw;
    in_brcond   = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    tbl[0]  = '{32'h0000_0000, 5'd1,  1'b1, 3'b100, 1'b1, 3'b001, 1'b1, 3'b100};
    tbl[1]  = '{32'h1111_0001, 5'd2,  1'b0, 3'b010, 1'b0, 3'b001, 1'b1, 3'b100};
    tbl[2]  = '{32'h2222_0002, 5'd3,  1'b1, 3'b000, 1'b0, 3'b010, 1'b0, 3'b100};
    tbl[3]  = '{32'h3333_0003, 5'd4,  1'b1, 3'b010, 1'b1, 3'b011, 1'b1, 3'b010};
    tbl[4]  = '{32'h4444_0004, 5'd5,  1'b0, 3'b111, 1'b0, 3'b011, 1'b1, 3'b010};
    tbl[5]  = '{32'h5555_0005, 5'd6,  1'b1, 3'b000, 1'b1, 3'b011, 1'b0, 3'b000};
    tbl[6]  = '{32'h6666_0006, 5'd7,  1'b1, 3'b000, 1'b0, 3'b100, 1'b1, 3'b000};
    tbl[7]  = '{32'h7777_0007, 5'd8,  1'b0, 3'b001, 1'b1, 3'b101, 1'b1, 3'b001};
    tbl[8]  = '{32'h8888_0008, 5'd9,  1'b1, 3'b000, 1'b0, 3'b101, 1'b1, 3'b001};
    tbl[9]  = '{32'h9999_0009, 5'd10, 1'b1, 3'b110, 1'b1, 3'b110, 1'b1, 3'b110};
    tbl[10] = '{32'hAAAA_000A, 5'd11, 1'b0, 3'b111, 1'b1, 3'b111, 1'b0, 3'b111};
    tbl[11] = '{32'hBBBB_000B, 5'd12, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 3'b111};
    tbl[12] = '{32'hFFFF_FFFF, 5'd31, 1'b1, 3'b000, 1'b1, 3'b010, 1'b1, 3'b000};

    // Reset with junk on the inputs
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 5'd7, 1'b1, 3'b111, 1'b1, 3'b110);
    tick();
    tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_sr", {29'b0, sr}, 32'd0);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_out_rd", {27'b0, out_rd}, 32'd0);
    chk("rst_out_rw", {31'b0, out_regwrite}, 32'd0);
    chk("rst_out_taken", {31'b0, out_taken}, 32'd0);
    rst_n = 1'b1;

    // Streaming: one result per cycle, output is the latest accept
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, tbl[i].sum, tbl[i].rd, tbl[i].rw,
            tbl[i].st, tbl[i].sw, tbl[i].br);
      tick();
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_ready", i), {31'b0, in_ready}, 32'd1);
      chk($sformatf("vec%0d_sum", i), out_sum, tbl[i].sum);
      chk($sformatf("vec%0d_rd", i), {27'b0, out_rd}, {27'b0, tbl[i].rd});
      chk($sformatf("vec%0d_rw", i), {31'b0, out_regwrite},
          {31'b0, tbl[i].rw});
      chk($sformatf("vec%0d_taken", i), {31'b0, out_taken},
          {31'b0, tbl[i].exp_tk});
      chk($sformatf("vec%0d_sr", i), {29'b0, sr}, {29'b0, tbl[i].exp_sr});
    end

    // Drain to EMPTY
    drive(1'b0, 32'h0, 5'd0, 1'b0, 3'b000, 1'b0, 3'b000);
    tick();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_hold_sum", out_sum, 32'hFFFF_FFFF);

    // Skid: A then B with writeback stalled
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_00AA, 5'd1, 1'b1, 3'b100, 1'b1, 3'b001);
    tick();
    chk("skidA_valid", {31'b0, out_valid}, 32'd1);
    chk("skidA_ready", {31'b0, in_ready}, 32'd1);
    chk("skidA_sum", out_sum, 32'h0000_00AA);
    drive(1'b1, 32'h0000_00BB, 5'd2, 1'b0, 3'b000, 1'b0, 3'b010);
    tick();
    chk("skidB_ready", {31'b0, in_ready}, 32'd0);
    chk("skidB_sum", out_sum, 32'h0000_00AA);
    chk("skidB_sr", {29'b0, sr}, 32'd4);
    // C must be refused while full
    drive(1'b1, 32'h0000_00CC, 5'd3, 1'b1, 3'b111, 1'b1, 3'b110);
    tick();
    chk("skidC_ready", {31'b0, in_ready}, 32'd0);
    chk("skidC_sum", out_sum, 32'h0000_00AA);
    chk("skidC_sr", {29'b0, sr}, 32'd4);
    chk("skidA_taken", {31'b0, out_taken}, 32'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 3'b000, 1'b0, 3'b000);
    out_ready = 1'b1;
    tick();
    chk("popA_valid", {31'b0, out_valid}, 32'd1);
    chk("popA_ready", {31'b0, in_ready}, 32'd1);
    chk("popA_sum", out_sum, 32'h0000_00BB);
    chk("popA_rd", {27'b0, out_rd}, 32'd2);
    chk("skidB_taken", {31'b0, out_taken}, 32'd0);
    tick();
    chk("popB_valid", {31'b0, out_valid}, 32'd0);
    chk("popB_ready", {31'b0, in_ready}, 32'd1);

    // Flush while full, with a status-writing input present
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_00DD, 5'd4, 1'b1, 3'b000, 1'b0, 3'b000);
    tick();
    drive(1'b1, 32'h0000_00EE, 5'd5, 1'b1, 3'b000, 1'b0, 3'b000);
    tick();
    chk("fill_ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'h0000_0F0F, 5'd6, 1'b1, 3'b001, 1'b1, 3'b101);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 3'b000, 1'b0, 3'b000);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_ready", {31'b0, in_ready}, 32'd1);
    chk("flush_sr", {29'b0, sr}, 32'd4);
    chk("flush_hold_sum", out_sum, 32'h0000_00DD);
    tick();
    chk("flush_stay_empty", {31'b0, out_valid}, 32'd0);

    // Reset while full
    drive(1'b1, 32'h0000_0123, 5'd8, 1'b1, 3'b011, 1'b1, 3'b000);
    tick();
    drive(1'b1, 32'h0000_0456, 5'd9, 1'b1, 3'b000, 1'b0, 3'b000);
    tick();
    chk("fill2_ready", {31'b0, in_ready}, 32'd0);
    chk("fill2_sr", {29'b0, sr}, 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 3'b000, 1'b0, 3'b000);
    chk("rst2_valid", {31'b0, out_valid}, 32'd0);
    chk("rst2_sr", {29'b0, sr}, 32'd0);
    chk("rst2_ready", {31'b0, in_ready}, 32'd1);
    chk("rst2_sum", out_sum, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
